// File: rtl/retire_unit_pkg.sv
// Shared types and defaults for the in-order retire stage.
//
// Contents:
//   RETIRE_WIDTH_DEF / SB_DEPTH_DEF : default parameter values
//   XLEN, AREG_W, PREG_W            : data, architectural reg and physical reg widths
//   robEntryStruct                  : one completed ROB head slot
//   regReqStruct                    : register-file write request
//   freeRegStruct                   : physical register returned to the free list
//   memReqStruct                    : store request toward data memory
package retire_unit_pkg;

  localparam int RETIRE_WIDTH_DEF = 2;
  localparam int SB_DEPTH_DEF     = 4;

  localparam int XLEN   = 32;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic              RegWrite;
    logic              MemWrite;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [XLEN-1:0]   result;   // ALU result; store address for MemWrite entries
    logic [XLEN-1:0]   wr_data;  // store data for MemWrite entries
  } robEntryStruct;

  typedef struct packed {
    logic              RegWrite;
    logic [AREG_W-1:0] rd;
    logic [XLEN-1:0]   wr_data;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
  } regReqStruct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] reg_addr;
  } freeRegStruct;

  typedef struct packed {
    logic            valid;
    logic            MemWrite;
    logic            MemRead;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wr_data;
  } memReqStruct;

endpackage

// File: rtl/retire_unit_store_buffer_fifo.sv
// Store buffer: a FIFO of memReqStruct that accepts up to MAX_PUSH entries per
// cycle (in slot order) and releases at most one per cycle.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (pointers/count cleared)
//   push_valid  : per-lane push enables; enabled lanes are packed in lane order
//   push_data   : per-lane store requests
//   pop         : remove the head entry (ignored when empty)
//   head        : oldest entry (contents undefined when empty)
//   count       : current occupancy, 0..DEPTH
//   empty       : count == 0
module store_buffer_fifo
  import retire_unit_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH_DEF,
  parameter int MAX_PUSH = RETIRE_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MAX_PUSH-1:0]          push_valid,
  input  memReqStruct                  push_data [MAX_PUSH],
  input  logic                         pop,
  output memReqStruct                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  memReqStruct      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] slot_off [MAX_PUSH];
  logic [31:0]      push_num;
  logic             pop_fire;

  // Each enabled lane lands at wr_ptr plus the number of enabled lanes below it,
  // so sparse push vectors still fill consecutive FIFO locations.
  always_comb begin
    push_num = '0;
    for (int i = 0; i < MAX_PUSH; i++) begin
      slot_off[i] = PTR_W'(push_num);
      if (push_valid[i]) push_num = push_num + 32'd1;
    end
  end

  assign empty    = (count == '0);
  assign pop_fire = pop && !empty;
  assign head     = mem[rd_ptr];

  // Storage needs no reset: validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_PUSH; i++) begin
      if (push_valid[i]) mem[wr_ptr + slot_off[i]] <= push_data[i];
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_num);
      rd_ptr <= rd_ptr + PTR_W'(pop_fire);
      count  <= OCC_W'(32'(count) + push_num - 32'(pop_fire));
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (32'(count) + push_num - 32'(pop_fire)) <= 32'(DEPTH));

endmodule

// File: rtl/retire_unit.sv
// In-order retire stage between the ROB head and architectural state.
// Each cycle it retires the oldest contiguous run of completed head slots,
// producing registered register-file writes / free-list returns and pushing
// stores into an internal store buffer that drains to memory.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   head_entry     : ROB head slots, slot 0 oldest; .valid = completed
//   retire_cnt     : slots popped from the ROB this cycle (combinational)
//   reg_req        : per-slot register-file writes, one cycle after retire
//   free_reg       : per-slot freed physical registers, one cycle after retire
//   mem_req        : store buffer head (all-zero when empty)
//   mem_req_valid  : store buffer non-empty
//   mem_req_ready  : memory accepts mem_req this cycle
//   sb_empty       : store buffer empty
//   err_illegal    : sticky; an entry with neither RegWrite nor MemWrite retired
//   retired_total  : wrapping count of retired entries
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int RETIRE_WIDTH = RETIRE_WIDTH_DEF,
  parameter int SB_DEPTH     = SB_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  robEntryStruct                       head_entry [RETIRE_WIDTH],
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]   retire_cnt,
  output regReqStruct                         reg_req [RETIRE_WIDTH],
  output freeRegStruct                        free_reg [RETIRE_WIDTH],
  output memReqStruct                         mem_req,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                sb_empty,
  output logic                                err_illegal,
  output logic [31:0]                         retired_total
);

  localparam int CNT_W = $clog2(RETIRE_WIDTH+1);
  localparam int OCC_W = $clog2(SB_DEPTH+1);

  logic [RETIRE_WIDTH-1:0] retire_vec;
  logic [RETIRE_WIDTH-1:0] illegal_vec;
  logic [RETIRE_WIDTH-1:0] push_valid;
  memReqStruct             push_data [RETIRE_WIDTH];
  logic [31:0]             scan_cnt;
  logic [31:0]             scan_stores;
  logic [31:0]             space;
  logic                    scan_stop;
  logic [OCC_W-1:0]        occupancy;
  memReqStruct             sb_head;
  logic                    sb_pop;

  // Space is taken from the registered occupancy only; a pop in this same
  // cycle is deliberately ignored so mem_req_ready never reaches retire_cnt.
  always_comb begin
    retire_vec  = '0;
    scan_cnt    = '0;
    scan_stores = '0;
    scan_stop   = 1'b0;
    space       = 32'(SB_DEPTH) - 32'(occupancy);
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (!scan_stop) begin
        if (!head_entry[i].valid) begin
          scan_stop = 1'b1;
        end else if (head_entry[i].MemWrite && (scan_stores >= space)) begin
          scan_stop = 1'b1;
        end else begin
          retire_vec[i] = 1'b1;
          scan_cnt      = scan_cnt + 32'd1;
          if (head_entry[i].MemWrite) scan_stores = scan_stores + 32'd1;
        end
      end
    end
    if (reset) begin
      retire_vec = '0;
      scan_cnt   = '0;
    end
  end

  assign retire_cnt = CNT_W'(scan_cnt);

  // A store that also claims RegWrite is treated purely as a store.
  always_comb begin
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      push_valid[i]  = retire_vec[i] && head_entry[i].MemWrite;
      illegal_vec[i] = retire_vec[i] && !head_entry[i].MemWrite && !head_entry[i].RegWrite;
      push_data[i]   = '{valid:    1'b1,
                         MemWrite: 1'b1,
                         MemRead:  1'b0,
                         addr:     head_entry[i].result,
                         wr_data:  head_entry[i].wr_data};
    end
  end

  store_buffer_fifo #(
    .DEPTH    (SB_DEPTH),
    .MAX_PUSH (RETIRE_WIDTH)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (sb_pop),
    .head       (sb_head),
    .count      (occupancy),
    .empty      (sb_empty)
  );

  assign mem_req_valid = !sb_empty;
  assign mem_req       = sb_empty ? '0 : sb_head;
  assign sb_pop        = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        reg_req[i]  <= '0;
        free_reg[i] <= '0;
      end
      err_illegal   <= 1'b0;
      retired_total <= '0;
    end else begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (retire_vec[i] && head_entry[i].RegWrite && !head_entry[i].MemWrite) begin
          reg_req[i]  <= '{RegWrite: 1'b1,
                           rd:       head_entry[i].rd,
                           wr_data:  head_entry[i].result,
                           rs1:      '0,
                           rs2:      '0};
          free_reg[i] <= '{valid: 1'b1, reg_addr: head_entry[i].rd_old};
        end else begin
          reg_req[i]  <= '0;
          free_reg[i] <= '0;
        end
      end
      if (|illegal_vec) err_illegal <= 1'b1;
      retired_total <= retired_total + 32'(retire_cnt);
    end
  end

endmodule

// File: tb/tb_retire_unit.sv
module tb_retire_unit;
  import retire_unit_pkg::*;

  localparam int W  = 3;
  localparam int D  = 4;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  robEntryStruct head_entry [W];
  logic [CW-1:0] retire_cnt;
  regReqStruct   reg_req [W];
  freeRegStruct  free_reg [W];
  memReqStruct   mem_req;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          sb_empty;
  logic          err_illegal;
  logic [31:0]   retired_total;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: store buffer as a queue, expected registered outputs.
  memReqStruct  sbq[$];
  regReqStruct  m_reg [W];
  freeRegStruct m_free [W];
  bit           m_err;
  logic [31:0]  m_total;

  retire_unit #(.RETIRE_WIDTH(W), .SB_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .head_entry    (head_entry),
    .retire_cnt    (retire_cnt),
    .reg_req       (reg_req),
    .free_reg      (free_reg),
    .mem_req       (mem_req),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .sb_empty      (sb_empty),
    .err_illegal   (err_illegal),
    .retired_total (retired_total)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic robEntryStruct mk(bit v, bit rw, bit mw, int rd, int rd_old,
                                       logic [31:0] res, logic [31:0] wd);
    robEntryStruct e;
    e.valid = v; e.RegWrite = rw; e.MemWrite = mw;
    e.rd = AREG_W'(rd); e.rd_old = PREG_W'(rd_old);
    e.result = res; e.wr_data = wd;
    return e;
  endfunction

  function automatic robEntryStruct rnd_entry();
    robEntryStruct e;
    int k;
    e.valid    = ($urandom_range(0, 4) != 0);
    k          = $urandom_range(0, 9);
    e.MemWrite = (k >= 1 && k <= 4);
    e.RegWrite = e.MemWrite ? 1'($urandom_range(0, 1)) : (k != 0);
    e.rd       = AREG_W'($urandom);
    e.rd_old   = PREG_W'($urandom);
    e.result   = $urandom;
    e.wr_data  = $urandom;
    return e;
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < W; i++) head_entry[i] = '0;
  endtask

  // Oldest-first scan: stop at an incomplete slot, or at a store with no room
  // left (room = capacity - queued - stores taken earlier in this scan).
  function automatic int model_cnt();
    int n = 0;
    int stores = 0;
    for (int i = 0; i < W; i++) begin
      if (!head_entry[i].valid) break;
      if (head_entry[i].MemWrite && (D - sbq.size() - stores) <= 0) break;
      if (head_entry[i].MemWrite) stores++;
      n++;
    end
    return n;
  endfunction

  task automatic model_clear();
    sbq.delete();
    for (int i = 0; i < W; i++) begin
      m_reg[i] = '0;
      m_free[i] = '0;
    end
    m_err = 1'b0;
    m_total = '0;
  endtask

  task automatic model_edge(int n);
    memReqStruct s;
    if (sbq.size() != 0 && mem_req_ready) void'(sbq.pop_front());
    for (int i = 0; i < W; i++) begin
      m_reg[i] = '0;
      m_free[i] = '0;
      if (i < n) begin
        if (head_entry[i].MemWrite) begin
          s.valid = 1'b1; s.MemWrite = 1'b1; s.MemRead = 1'b0;
          s.addr = head_entry[i].result; s.wr_data = head_entry[i].wr_data;
          sbq.push_back(s);
        end else if (head_entry[i].RegWrite) begin
          m_reg[i].RegWrite = 1'b1;
          m_reg[i].rd = head_entry[i].rd;
          m_reg[i].wr_data = head_entry[i].result;
          m_free[i].valid = 1'b1;
          m_free[i].reg_addr = head_entry[i].rd_old;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    m_total = m_total + 32'(n);
  endtask

  task automatic check_outputs();
    memReqStruct exp_mem;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("reg_req[%0d]", i), 128'(reg_req[i]), 128'(m_reg[i]));
      chk($sformatf("free_reg[%0d]", i), 128'(free_reg[i]), 128'(m_free[i]));
    end
    exp_mem = (sbq.size() != 0) ? sbq[0] : '0;
    chk("mem_req_valid", 128'(mem_req_valid), 128'(sbq.size() != 0));
    chk("sb_empty", 128'(sb_empty), 128'(sbq.size() == 0));
    chk("mem_req", 128'(mem_req), 128'(exp_mem));
    chk("err_illegal", 128'(err_illegal), 128'(m_err));
    chk("retired_total", 128'(retired_total), 128'(m_total));
  endtask

  // Called at posedge+1 with inputs set; checks the combinational count,
  // advances the model across the edge, then checks registered outputs.
  task automatic step(int lit);
    int n;
    #3;
    n = model_cnt();
    chk("retire_cnt", 128'(retire_cnt), 128'(n));
    if (lit >= 0) chk("retire_cnt_lit", 128'(retire_cnt), 128'(lit));
    model_edge(n);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    #3;
    chk("retire_cnt_in_reset", 128'(retire_cnt), 128'(0));
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();
    chk("rst_sb_empty", 128'(sb_empty), 128'(1));
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_retired_total", 128'(retired_total), 128'(0));
    chk("rst_err_illegal", 128'(err_illegal), 128'(0));
  endtask

  initial begin
    regReqStruct  er;
    freeRegStruct ef;
    int           ready_pct;

    clear_slots();
    @(posedge clk);
    #1;
    reset_cycle();

    // Single register write, slot 1 not complete.
    clear_slots();
    head_entry[0] = mk(1, 1, 0, 5, 40, 32'h1234, 32'h0);
    step(1);
    er = '0; er.RegWrite = 1'b1; er.rd = 5'd5; er.wr_data = 32'h1234;
    ef = '0; ef.valid = 1'b1; ef.reg_addr = 6'd40;
    chk("reg_req0_lit", 128'(reg_req[0]), 128'(er));
    chk("free_reg0_lit", 128'(free_reg[0]), 128'(ef));
    chk("reg_req1_lit", 128'(reg_req[1]), 128'(0));

    // Two stores, memory stalled, then drained in order.
    clear_slots();
    head_entry[0] = mk(1, 0, 1, 0, 0, 32'h100, 32'hA);
    head_entry[1] = mk(1, 0, 1, 0, 0, 32'h104, 32'hB);
    mem_req_ready = 1'b0;
    step(2);
    chk("st_valid_lit", 128'(mem_req_valid), 128'(1));
    chk("st_addr0_lit", 128'(mem_req.addr), 128'(32'h100));
    clear_slots();
    step(0);
    chk("st_addr0_held_lit", 128'(mem_req.addr), 128'(32'h100));
    mem_req_ready = 1'b1;
    step(0);
    chk("st_addr1_lit", 128'(mem_req.addr), 128'(32'h104));
    chk("st_data1_lit", 128'(mem_req.wr_data), 128'(32'hB));
    step(0);
    chk("st_drained_lit", 128'(sb_empty), 128'(1));

    // Buffer at 3/4: only one more store fits, a same-cycle pop does not help.
    mem_req_ready = 1'b0;
    head_entry[0] = mk(1, 0, 1, 0, 0, 32'h200, 32'h1);
    head_entry[1] = mk(1, 0, 1, 0, 0, 32'h204, 32'h2);
    head_entry[2] = mk(1, 0, 1, 0, 0, 32'h208, 32'h3);
    step(3);
    head_entry[0] = mk(1, 0, 1, 0, 0, 32'h300, 32'h4);
    head_entry[1] = mk(1, 0, 1, 0, 0, 32'h304, 32'h5);
    head_entry[2] = '0;
    mem_req_ready = 1'b1;
    step(1);
    chk("full_head_lit", 128'(mem_req.addr), 128'(32'h204));
    clear_slots();
    for (int k = 0; k < 5; k++) step(0);

    // RegWrite, illegal, RegWrite.
    head_entry[0] = mk(1, 1, 0, 1, 11, 32'hAAAA, 32'h0);
    head_entry[1] = mk(1, 0, 0, 2, 12, 32'hBBBB, 32'h0);
    head_entry[2] = mk(1, 1, 0, 3, 13, 32'hCCCC, 32'h0);
    step(3);
    chk("illegal_err_lit", 128'(err_illegal), 128'(1));
    chk("illegal_rr0_lit", 128'(reg_req[0].RegWrite), 128'(1));
    chk("illegal_rr1_lit", 128'(reg_req[1]), 128'(0));
    chk("illegal_rr2_lit", 128'(reg_req[2].wr_data), 128'(32'hCCCC));
    clear_slots();
    step(0);
    chk("illegal_sticky_lit", 128'(err_illegal), 128'(1));

    // Gap at slot 0 blocks younger completed slots.
    head_entry[1] = mk(1, 1, 0, 7, 17, 32'h77, 32'h0);
    step(0);
    chk("gap_rr1_lit", 128'(reg_req[1]), 128'(0));
    chk("gap_fr1_lit", 128'(free_reg[1]), 128'(0));

    // Reset with stores buffered.
    mem_req_ready = 1'b0;
    head_entry[0] = mk(1, 0, 1, 0, 0, 32'h400, 32'h1);
    head_entry[1] = mk(1, 0, 1, 0, 0, 32'h404, 32'h2);
    head_entry[2] = mk(1, 0, 1, 0, 0, 32'h408, 32'h3);
    step(3);
    clear_slots();
    reset_cycle();

    // Randomized traffic with alternating memory back-pressure phases.
    for (int c = 0; c < 3000; c++) begin
      ready_pct = ((c / 200) % 2 == 1) ? 20 : 80;
      for (int i = 0; i < W; i++) head_entry[i] = rnd_entry();
      mem_req_ready = ($urandom_range(0, 99) < ready_pct);
      if (c == 1500) begin
        reset_cycle();
      end else begin
        step(-1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
# retire_unit

Parametrised N-wide in-order retire stage between the reorder buffer head and architectural state. Each cycle it retires the oldest contiguous run of completed ROB entries. Register-writing entries produce a registered register-file write and a physical-register free. Store entries are pushed into an internal store buffer that drains to data memory through a valid/ready handshake. Retirement stalls when the store buffer cannot accept further stores.

## Interface
- RETIRE_WIDTH, 2, ROB head slots examined per cycle (1–8); slot 0 is oldest.
- SB_DEPTH, 4, store buffer entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- head_entry  in  RETIRE_WIDTH × robEntryStruct  ROB head slots; .valid means completed and ready to retire.
- retire_cnt  out  $clog2(RETIRE_WIDTH+1)  entries the ROB pops this cycle (combinational).
- reg_req  out  RETIRE_WIDTH × regReqStruct  register-file writes (registered).
- free_reg  out  RETIRE_WIDTH × freeRegStruct  old physical registers returned to the free list (registered).
- mem_req  out  memReqStruct  head of store buffer.
- mem_req_valid  out  1  store buffer non-empty.
- mem_req_ready  in  1  memory accepts mem_req this cycle.
- sb_empty  out  1  store buffer empty (fence/drain status).
- err_illegal  out  1  sticky; an entry with neither RegWrite nor MemWrite was retired.
- retired_total  out  32  free-running count of retired entries; wraps.

## Operation
- Retire scan runs from slot 0 upward and stops at the first slot meeting any of:
  - .valid=0;
  - MemWrite=1 with no store-buffer space left, where space = SB_DEPTH − occupancy at cycle start − stores already accepted earlier in this scan.
- retire_cnt is the number of slots passed before the scan stops. Slots above the stop point are never retired, even if valid.
- Dequeue in the same cycle does not create space. This prevents a combinational path from mem_req_ready to retire_cnt.
- Retired MemWrite entry:
  - enqueue {addr=result, wr_data=wr_data, MemWrite=1, MemRead=0, valid=1}, preserving slot order;
  - no reg_req and no free_reg for that slot.
- Retired RegWrite entry (MemWrite=0): next cycle, reg_req[i] = {RegWrite=1, rd, wr_data=result, rs1=0, rs2=0} and free_reg[i] = {valid=1, reg_addr=rd_old}. Index i is the head slot index.
- Retired entry with neither flag: counted in retire_cnt, no side effect, sets err_illegal.
- Unretired slots: reg_req[i] and free_reg[i] are all-zero the next cycle.
- Store buffer is a FIFO:
  - pop when mem_req_valid && mem_req_ready;
  - multi-push (up to RETIRE_WIDTH) and pop may occur in the same cycle;
  - occupancy' = occupancy + pushes − pop.
- retired_total += retire_cnt every cycle, modulo 2^32.

## Timing
- Reset values:
  - reg_req and free_reg all-zero;
  - store buffer emptied, pointers and count 0; mem_req all-zero, mem_req_valid=0, sb_empty=1;
  - err_illegal=0, retired_total=0.
- retire_cnt is combinational from head_entry and registered occupancy. During reset it is forced to 0.
- reg_req/free_reg latency: 1 cycle after the retiring edge.
- Store latency: retire at edge N, so mem_req_valid is high from cycle N+1 at the earliest.
- mem_req stays stable while mem_req_valid && !mem_req_ready.
- Full: occupancy=SB_DEPTH blocks the first store slot; register slots before it still retire.
- Pointer wrap: natural modulo SB_DEPTH; count width is $clog2(SB_DEPTH+1).
- Reset mid-drain: buffered stores are discarded; the outstanding request is dropped (memory side must tolerate this).

## Structure
- Package typedefs keeps robEntryStruct, regReqStruct, memReqStruct, freeRegStruct.
- Add to the package: RETIRE_WIDTH_DEF and SB_DEPTH_DEF constants.
- Sub-module store_buffer_fifo (params DEPTH, MAX_PUSH):
  - inputs: push vector, pop;
  - outputs: head, count, empty;
  - instantiated once.
- Top level holds the scan/prefix logic, output registers, sticky error and counter.
- Assertion: store buffer never overflows.

## Test plan
- RETIRE_WIDTH=2: slot0 RegWrite rd=5 rd_old=40 result=0x1234, slot1 valid=0 → retire_cnt=1; next cycle reg_req[0]={1,5,0x1234}, free_reg[0]={1,40}, reg_req[1]=0.
- Two stores (addr 0x100, 0x104), mem_req_ready=0, SB_DEPTH=4 → retire_cnt=2; mem_req_valid next cycle with addr 0x100; held until ready; after ready, 0x104.
- Buffer at 3/4, slots = store, store → retire_cnt=1, second store waits; the same-cycle pop does not let it retire.
- Slots = RegWrite, illegal, RegWrite → retire_cnt=3, err_illegal=1 and sticky; only reg_req[0] and reg_req[2] active.
- Slot0 valid=0, slot1 valid RegWrite → retire_cnt=0, no outputs next cycle.
- Assert reset with 3 buffered stores → next cycle sb_empty=1, mem_req_valid=0, retired_total=0, err_illegal=0.
